pico_mem_bus: RTL and testbench

PICO_MEM_BUS -- requirements
Module: pico_mem_bus

---
 rtl/pico_mem_pkg.sv | 7 +
 rtl/pico_mem_fifo.sv | 38 +++
 rtl/pico_mem_bus.sv | 109 ++++++++++
 tb/tb_pico_mem_bus.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/pico_mem_pkg.sv
// pico_mem_pkg: shared FSM state, region decode and console status layout for pico_mem_bus.
package pico_mem_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    typedef enum logic [1:0] {RAM, CONS, NONE} region_t;
    localparam int CONS_FULL_BIT  = 0;
    localparam int CONS_COUNT_LSB = 8;
endpackage

// File: rtl/pico_mem_fifo.sv
// pico_mem_fifo: byte FIFO feeding the console sink; a push into a full FIFO succeeds only alongside a pop.
module pico_mem_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [7:0]               din,
    input  logic                     pop,
    output logic [7:0]               dout,
    output logic                     valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wp, rp;
    logic          do_push, do_pop;
    assign valid   = count != '0;
    assign full    = count == CW'(DEPTH);
    assign dout    = valid ? mem[rp] : 8'h0;
    assign do_pop  = pop && valid;
    assign do_push = push && (!full || do_pop);
    always_ff @(posedge clk)
        if (do_push) mem[wp] <= din;
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            wp    <= do_push ? wp + 1'b1 : wp;
            rp    <= do_pop ? rp + 1'b1 : rp;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/pico_mem_bus.sv
// pico_mem_bus: picorv32-style memory slave with RAM, optional console FIFO (PICO_MEM_CONSOLE_EN) and bus error.
module pico_mem_bus
    import pico_mem_pkg::*;
#(
    parameter int          MEM_WORDS   = 256,
    parameter int          WAIT_STATES = 0,
    parameter int          CONS_DEPTH  = 4,
    parameter logic [31:0] CONS_ADDR   = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic        mem_instr,
    output logic        mem_ready,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    output logic        cons_valid,
    input  logic        cons_ready,
    output logic [7:0]  cons_data,
    output logic        bus_err
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam int CW = $clog2(CONS_DEPTH) + 1;
    state_t       state;
    region_t      region;
    logic [3:0]   cnt;
    logic [31:0]  a_addr, a_wdata;
    logic [3:0]   a_wstrb;
    logic [31:0]  ram [MEM_WORDS];
    logic [31:0]  cons_status;
    logic [CW-1:0] cons_count;
    logic         is_ram, cons_hit, is_cons, cons_wr, cons_full, cons_pop, stall, fire;
    logic         unused_ok;
    assign is_ram   = a_addr < 32'(MEM_WORDS * 4);
    assign cons_hit = a_addr[31:2] == CONS_ADDR[31:2];
    assign region   = is_ram ? RAM : is_cons ? CONS : NONE;
    assign cons_wr  = region == CONS && a_wstrb[0];
    assign cons_pop = cons_valid && cons_ready;
    // A console write into a full FIFO waits unless the sink frees a slot this very cycle.
    assign stall    = cons_wr && cons_full && !cons_pop;
    assign fire     = state == WAIT && cnt == 4'd0 && !stall;
    assign unused_ok = &{1'b0, mem_instr, a_addr[1:0], cons_hit};
    always_comb begin
        cons_status = '0;
        cons_status[CONS_COUNT_LSB +: 8] = 8'(cons_count);
        cons_status[CONS_FULL_BIT] = cons_full;
    end
`ifdef PICO_MEM_CONSOLE_EN
    logic cons_push;
    assign is_cons   = cons_hit;
    assign cons_push = fire && cons_wr;
    pico_mem_fifo #(.DEPTH(CONS_DEPTH)) u_fifo (
        .clk(clk),
        .resetn(resetn),
        .push(cons_push),
        .din(a_wdata[7:0]),
        .pop(cons_pop),
        .dout(cons_data),
        .valid(cons_valid),
        .full(cons_full),
        .count(cons_count)
    );
`else
    assign is_cons    = 1'b0;
    assign cons_valid = 1'b0;
    assign cons_data  = 8'h0;
    assign cons_full  = 1'b0;
    assign cons_count = '0;
`endif
    always_ff @(posedge clk)
        if (resetn && fire && region == RAM)
            for (int i = 0; i < 4; i++)
                if (a_wstrb[i]) ram[a_addr[AW+1:2]][8*i +: 8] <= a_wdata[8*i +: 8];
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            mem_ready <= 1'b0;
            mem_rdata <= 32'h0;
            bus_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (mem_valid && !mem_ready) begin
                    a_addr  <= mem_addr;
                    a_wdata <= mem_wdata;
                    a_wstrb <= mem_wstrb;
                    cnt     <= 4'(WAIT_STATES);
                    state   <= WAIT;
                end
                WAIT: if (cnt != 4'd0) begin
                    cnt <= cnt - 4'd1;
                end else if (!stall) begin
                    state     <= RESP;
                    mem_ready <= 1'b1;
                    bus_err   <= region == NONE;
                    mem_rdata <= region == RAM ? ram[a_addr[AW+1:2]] : region == CONS ? cons_status : 32'h0;
                end
                RESP: begin
                    mem_ready <= 1'b0;
                    bus_err   <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pico_mem_bus.sv
// tb_pico_mem_bus: two instances (WAIT_STATES 0 and 3) checked each cycle against a transaction-level model.
module tb_pico_mem_bus;
    localparam logic [31:0] CONS_ADDR = 32'h1000_0000;
    localparam int CD = 4;
`ifdef PICO_MEM_CONSOLE_EN
    localparam bit CONS_EN = 1'b1;
`else
    localparam bit CONS_EN = 1'b0;
`endif
    localparam int WS [2] = '{0, 3};

    logic        clk, resetn;
    logic        mem_valid [2], mem_instr [2], mem_ready [2], cons_valid [2], cons_ready [2], bus_err [2];
    logic [31:0] mem_addr [2], mem_wdata [2], mem_rdata [2];
    logic [3:0]  mem_wstrb [2];
    logic [7:0]  cons_data [2];

    int tests = 0;
    int fails = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        pico_mem_bus #(.WAIT_STATES(g * 3), .CONS_ADDR(CONS_ADDR)) u_dut (
            .clk(clk), .resetn(resetn),
            .mem_valid(mem_valid[g]), .mem_instr(mem_instr[g]), .mem_ready(mem_ready[g]),
            .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]), .mem_wstrb(mem_wstrb[g]),
            .mem_rdata(mem_rdata[g]), .cons_valid(cons_valid[g]), .cons_ready(cons_ready[g]),
            .cons_data(cons_data[g]), .bus_err(bus_err[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Transaction-level model: pending request ages until its latency is met, RAM as sparse words, FIFO as queue.
    bit          pend [2], rprev [2], resp_m [2], err_m [2], lknown [2], hv [2];
    int          age [2];
    logic [31:0] t_addr [2], t_wdata [2], last [2];
    logic [3:0]  t_wstrb [2];
    logic [7:0]  hd [2];
    logic [7:0]  q [2][$];
    logic [7:0]  dpop [2][$];
    logic [31:0] mram [int];

    function automatic int region_of(input logic [31:0] a);
        if (a < 32'd1024) return 0;
        if (CONS_EN && a[31:2] == CONS_ADDR[31:2]) return 1;
        return 2;
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            bit pop_m, push_m;
            int rg, key, sz;
            resp_m[d] = 1'b0;
            err_m[d]  = 1'b0;
            if (!resetn) begin
                pend[d] = 1'b0; rprev[d] = 1'b0; last[d] = 32'h0; lknown[d] = 1'b1;
                q[d].delete();
            end else begin
                if (cons_ready[d] && hv[d]) dpop[d].push_back(hd[d]);
                sz     = q[d].size();
                pop_m  = cons_ready[d] && sz > 0;
                push_m = 1'b0;
                if (rprev[d]) rprev[d] = 1'b0;
                else if (pend[d]) begin
                    age[d]++;
                    rg = region_of(t_addr[d]);
                    if (age[d] >= 1 + WS[d] && !(rg == 1 && t_wstrb[d][0] && sz == CD && !pop_m)) begin
                        resp_m[d] = 1'b1; pend[d] = 1'b0; rprev[d] = 1'b1; lknown[d] = 1'b1;
                        if (rg == 0) begin
                            key = d * 4096 + int'(t_addr[d][9:2]);
                            lknown[d] = mram.exists(key);
                            last[d] = lknown[d] ? mram[key] : 32'h0;
                            if (t_wstrb[d] == 4'hF) mram[key] = t_wdata[d];
                            else if (t_wstrb[d] != 4'h0 && lknown[d])
                                for (int i = 0; i < 4; i++)
                                    if (t_wstrb[d][i]) mram[key][8*i +: 8] = t_wdata[d][8*i +: 8];
                        end else if (rg == 1) begin
                            last[d] = {16'h0, 8'(sz), 7'h0, sz == CD};
                            push_m = t_wstrb[d][0];
                        end else begin
                            last[d] = 32'h0;
                            err_m[d] = 1'b1;
                        end
                    end
                end else if (mem_valid[d]) begin
                    pend[d] = 1'b1; age[d] = 0;
                    t_addr[d] = mem_addr[d]; t_wdata[d] = mem_wdata[d]; t_wstrb[d] = mem_wstrb[d];
                end
                if (pop_m) void'(q[d].pop_front());
                if (push_m) q[d].push_back(t_wdata[d][7:0]);
            end
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("ready%0d", d), 32'(mem_ready[d]), 32'(resp_m[d]));
            chk($sformatf("bus_err%0d", d), 32'(bus_err[d]), 32'(err_m[d]));
            if (lknown[d]) chk($sformatf("rdata%0d", d), mem_rdata[d], last[d]);
            chk($sformatf("cons_valid%0d", d), 32'(cons_valid[d]), 32'(q[d].size() > 0));
            chk($sformatf("cons_data%0d", d), 32'(cons_data[d]), 32'(q[d].size() > 0 ? q[d][0] : 8'h0));
            hv[d] = cons_valid[d];
            hd[d] = cons_data[d];
        end
    end

    task automatic xact(input int d, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                        input bit drop, output logic [31:0] rd, output int lat, output logic er);
        int n = 0;
        bit got = 1'b0;
        @(negedge clk);
        mem_valid[d] = 1'b1; mem_addr[d] = a; mem_wdata[d] = wd; mem_wstrb[d] = ws;
        while (!got && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (drop) mem_valid[d] = 1'b0;
            got = mem_ready[d];
        end
        rd = mem_rdata[d]; er = bus_err[d]; lat = n - 1;
        mem_valid[d] = 1'b0;
        if (!got) begin
            tests++; fails++;
            $display("FAIL timeout: no mem_ready on dut %0d addr %h within 100 cycles", d, a);
        end
        @(posedge clk);
    endtask

    initial begin
        logic [31:0] rd;
        int          lat;
        logic        er;
        resetn = 1'b0;
        for (int d = 0; d < 2; d++) begin
            mem_valid[d] = 0; mem_instr[d] = 0; mem_addr[d] = 0; mem_wdata[d] = 0; mem_wstrb[d] = 0;
            cons_ready[d] = 0;
        end
        repeat (3) @(negedge clk);
        chk("reset_ready", 32'(mem_ready[0]), 32'd0);
        chk("reset_rdata", mem_rdata[1], 32'h0);
        chk("reset_cons_valid", 32'(cons_valid[0]), 32'd0);
        resetn = 1'b1;

        xact(0, 32'h3FC, 32'h1234_5678, 4'hF, 0, rd, lat, er);
        chk("sw_latency", 32'(lat), 32'd1);
        xact(0, 32'h3FC, 32'h0, 4'h0, 0, rd, lat, er);
        chk("lw_latency", 32'(lat), 32'd1);
        chk("lw_data", rd, 32'h1234_5678);
        chk("lw_err", 32'(er), 32'd0);

        xact(0, 32'h10, 32'h1122_3344, 4'hF, 0, rd, lat, er);
        xact(0, 32'h10, 32'h00AB_0000, 4'b0100, 0, rd, lat, er);
        chk("byte_wr_prewrite", rd, 32'h1122_3344);
        xact(0, 32'h13, 32'h0, 4'h0, 0, rd, lat, er);
        chk("byte_wr_merge", rd, 32'h11AB_3344);

        xact(1, 32'h20, 32'hCAFE_F00D, 4'hF, 0, rd, lat, er);
        chk("ws3_wr_latency", 32'(lat), 32'd4);
        xact(1, 32'h20, 32'h0, 4'h0, 1, rd, lat, er);
        chk("ws3_rd_latency", 32'(lat), 32'd4);
        chk("ws3_drop_data", rd, 32'hCAFE_F00D);

        xact(0, 32'h2000_0000, 32'h0, 4'h0, 0, rd, lat, er);
        chk("unmapped_rdata", rd, 32'h0);
        chk("unmapped_err", 32'(er), 32'd1);
        chk("unmapped_latency", 32'(lat), 32'd1);
        xact(0, 32'h2000_03FC, 32'hDEAD_BEEF, 4'hF, 0, rd, lat, er);
        xact(0, 32'h3FC, 32'h0, 4'h0, 0, rd, lat, er);
        chk("unmapped_no_alias", rd, 32'h1234_5678);

`ifdef PICO_MEM_CONSOLE_EN
        for (int i = 0; i < 4; i++) xact(0, CONS_ADDR, 32'h41 + 32'(i), 4'b0001, 0, rd, lat, er);
        xact(0, CONS_ADDR, 32'h0, 4'h0, 0, rd, lat, er);
        chk("cons_status_full", rd, 32'h0000_0401);
        fork
            xact(0, CONS_ADDR, 32'h45, 4'b0001, 0, rd, lat, er);
            begin
                repeat (6) @(negedge clk);
                chk("cons_stall", 32'(mem_ready[0]), 32'd0);
                cons_ready[0] = 1'b1;
            end
        join
        repeat (8) @(negedge clk);
        chk("cons_pop_count", 32'(dpop[0].size()), 32'd5);
        for (int i = 0; i < 5 && i < dpop[0].size(); i++)
            chk($sformatf("cons_order%0d", i), 32'(dpop[0][i]), 32'h41 + 32'(i));
        xact(0, CONS_ADDR, 32'h5A, 4'b0010, 0, rd, lat, er);
        chk("cons_nopush_err", 32'(er), 32'd0);
        xact(0, CONS_ADDR, 32'h0, 4'h0, 0, rd, lat, er);
        chk("cons_status_empty", rd, 32'h0);
        cons_ready[0] = 1'b0;
`else
        xact(0, CONS_ADDR, 32'h41, 4'b0001, 0, rd, lat, er);
        chk("cons_off_wr_err", 32'(er), 32'd1);
        xact(0, CONS_ADDR, 32'h0, 4'h0, 0, rd, lat, er);
        chk("cons_off_rd_data", rd, 32'h0);
        chk("cons_off_valid", 32'(cons_valid[0]), 32'd0);
`endif

        xact(1, 32'h40, 32'h0102_0304, 4'hF, 0, rd, lat, er);
        @(negedge clk);
        mem_valid[1] = 1'b1; mem_addr[1] = 32'h40; mem_wdata[1] = 32'hFFFF_FFFF; mem_wstrb[1] = 4'hF;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b0; mem_valid[1] = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        chk("abort_ready", 32'(mem_ready[1]), 32'd0);
        chk("abort_fifo_empty", 32'(cons_valid[0]), 32'd0);
        xact(1, 32'h40, 32'h0, 4'h0, 0, rd, lat, er);
        chk("abort_no_write", rd, 32'h0102_0304);
        chk("post_reset_latency", 32'(lat), 32'd4);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
